// File: rtl/run_test_readout_pkg.sv
// Shared definitions for the runs/ones counter readout: default geometry,
// the frame FSM states and the frame-layout helper functions.
package run_test_pkg;

  localparam int          LANES_DEF  = 32;
  localparam int          CW_DEF     = 64;
  localparam int          WORD_W_DEF = 32;
  localparam logic [15:0] MAGIC_DEF  = 16'hA55A;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    TOT,
    LANE,
    FIN
  } state_t;

  // Words per frame: header, the total, then a run/ones counter pair per lane.
  function automatic int frame_len(input int lanes, input int cw, input int word_w);
    return 1 + (cw / word_w) * (1 + 2 * lanes);
  endfunction

  // Header word: tag, lane count and words-per-counter, so the host can
  // size the rest of the frame without out-of-band knowledge.
  function automatic logic [31:0] hdr_word(input logic [15:0] magic, input int lanes,
                                           input int wpc);
    logic [7:0] lanes8;
    logic [7:0] wpc8;
    lanes8 = 8'(lanes);
    wpc8   = 8'(wpc);
    return {magic, lanes8, wpc8};
  endfunction

endpackage

// File: rtl/run_test_readout_word_mux_reg.sv
// Output word register for the readout stream: picks one WORD_W slice of a
// CW-bit snapshot counter (or the header) and holds it steady while the
// downstream side stalls.
module word_mux_reg
  import run_test_pkg::*;
#(
  parameter int CW     = CW_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int SW     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              use_hdr,
  input  logic [WORD_W-1:0] hdr_data,
  input  logic [CW-1:0]     src_word,
  input  logic [SW-1:0]     sub_idx,
  input  logic              last_in,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last
);

  localparam int WPC = CW / WORD_W;

  logic [WORD_W-1:0] words [WPC];
  logic [WORD_W-1:0] sel_word;

  // Slice word gi is the gi-th least-significant WORD_W chunk of the counter.
  generate
    for (genvar gi = 0; gi < WPC; gi++) begin : g_split
      assign words[gi] = src_word[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign sel_word = use_hdr ? hdr_data : words[sub_idx];

  // Load a new word, drop valid after the final transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= sel_word;
      out_valid <= 1'b1;
      out_last  <= last_in;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/run_test_readout.sv
// Reader side of the per-lane runs/ones counter bank. A start request freezes
// every counter into a snapshot in one cycle; the snapshot is then streamed as
// a framed sequence of words over valid/ready, so the live counters can be
// cleared or keep counting while the frame is in flight.
module run_test_readout
  import run_test_pkg::*;
#(
  parameter int          LANES  = LANES_DEF,
  parameter int          CW     = CW_DEF,
  parameter int          WORD_W = WORD_W_DEF,
  parameter logic [15:0] MAGIC  = MAGIC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CW-1:0]     run_count [LANES-1:0],
  input  logic [CW-1:0]     one_count [LANES-1:0],
  input  logic [CW-1:0]     total,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int WPC       = CW / WORD_W;
  localparam int FRAME_LEN = frame_len(LANES, CW, WORD_W);
  localparam int SW        = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [SW-1:0]     SUB_MAX  = SW'(WPC - 1);
  localparam logic [LW-1:0]     LANE_MAX = LW'(LANES - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(FRAME_LEN - 1);
  localparam logic [WORD_W-1:0] HDR_WORD = WORD_W'(hdr_word(MAGIC, LANES, WPC));

  // Frozen copy of the counter bank; deliberately not cleared by reset.
  logic [CW-1:0] run_snap [LANES];
  logic [CW-1:0] one_snap [LANES];
  logic [CW-1:0] tot_snap;

  // Position of the word currently held in the output register.
  state_t        state_reg, state_next;
  logic [SW-1:0] sub_reg, sub_next;
  logic [LW-1:0] lane_reg, lane_next;
  logic          sel_one_reg, sel_one_next;
  logic [IW-1:0] idx_reg, idx_next;

  logic          capture;
  logic          xfer;
  logic          load;
  logic          clear;
  logic          use_hdr;
  logic          last_word;
  logic [CW-1:0] src_word;

  assign capture = (state_reg == IDLE) && start;
  assign xfer    = out_valid && out_ready;

  // Freeze the whole counter bank on the cycle a frame is launched.
  always_ff @(posedge clk) begin
    if (capture) begin
      tot_snap <= total;
      for (int i = 0; i < LANES; i++) begin
        run_snap[i] <= run_count[i];
        one_snap[i] <= one_count[i];
      end
    end
  end

  // Frame position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sub_reg     <= '0;
      lane_reg    <= '0;
      sel_one_reg <= 1'b0;
      idx_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      sub_reg     <= sub_next;
      lane_reg    <= lane_next;
      sel_one_reg <= sel_one_next;
      idx_reg     <= idx_next;
    end
  end

  // Advance to the next word on each accepted transfer and tell the output
  // register what to load; the position describes the word being presented.
  always_comb begin
    state_next   = state_reg;
    sub_next     = sub_reg;
    lane_next    = lane_reg;
    sel_one_next = sel_one_reg;
    idx_next     = idx_reg;
    load         = 1'b0;
    clear        = 1'b0;
    use_hdr      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = HDR;
          load         = 1'b1;
          use_hdr      = 1'b1;
          idx_next     = '0;
          sub_next     = '0;
          lane_next    = '0;
          sel_one_next = 1'b0;
        end
      end
      HDR: begin
        if (xfer) begin
          state_next = TOT;
          load       = 1'b1;
          sub_next   = '0;
          idx_next   = idx_reg + IW'(1);
        end
      end
      TOT: begin
        if (xfer) begin
          load     = 1'b1;
          idx_next = idx_reg + IW'(1);
          if (sub_reg == SUB_MAX) begin
            state_next   = LANE;
            sub_next     = '0;
            lane_next    = '0;
            sel_one_next = 1'b0;
          end else begin
            sub_next = sub_reg + SW'(1);
          end
        end
      end
      LANE: begin
        if (xfer) begin
          if (sub_reg != SUB_MAX) begin
            load     = 1'b1;
            sub_next = sub_reg + SW'(1);
            idx_next = idx_reg + IW'(1);
          end else if (!sel_one_reg) begin
            load         = 1'b1;
            sub_next     = '0;
            sel_one_next = 1'b1;
            idx_next     = idx_reg + IW'(1);
          end else if (lane_reg != LANE_MAX) begin
            load         = 1'b1;
            sub_next     = '0;
            sel_one_next = 1'b0;
            lane_next    = lane_reg + LW'(1);
            idx_next     = idx_reg + IW'(1);
          end else begin
            // Final word accepted: indices wrap for the next frame.
            state_next   = FIN;
            clear        = 1'b1;
            sub_next     = '0;
            sel_one_next = 1'b0;
            lane_next    = '0;
            idx_next     = '0;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pick the snapshot counter that the next word is sliced from.
  always_comb begin
    src_word = tot_snap;
    if (state_next == LANE) begin
      src_word = sel_one_next ? one_snap[lane_next] : run_snap[lane_next];
    end
  end

  assign last_word = (idx_next == IDX_LAST);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == FIN);

  word_mux_reg #(
    .CW     (CW),
    .WORD_W (WORD_W),
    .SW     (SW)
  ) u_word_mux_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .clear     (clear),
    .use_hdr   (use_hdr),
    .hdr_data  (HDR_WORD),
    .src_word  (src_word),
    .sub_idx   (sub_next),
    .last_in   (last_word),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_run_test_readout.sv
// Bench for run_test_readout: a frame model fills an expected-word queue when
// a start is issued, and an independent monitor pops and compares every word
// the DUT hands over. A second small instance covers the LANES=4, CW=32 case.
`timescale 1ns/1ps
module tb_run_test_readout;

  localparam int LANES = 32;
  localparam int CW    = 64;
  localparam int WW    = 32;
  localparam int WPC   = CW / WW;

  typedef struct {
    logic [WW-1:0] data;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [CW-1:0] run_count [LANES-1:0];
  logic [CW-1:0] one_count [LANES-1:0];
  logic [CW-1:0] total;
  logic [WW-1:0] out_data;
  logic          out_valid, out_last, busy, done;

  logic          s_start = 1'b0;
  logic          s_ready = 1'b1;
  logic [31:0]   s_run [3:0];
  logic [31:0]   s_one [3:0];
  logic [31:0]   s_total;
  logic [31:0]   s_data;
  logic          s_valid, s_last, s_busy, s_done;

  int checks = 0;
  int errors = 0;

  word_t       exp_q [$];
  int          exp_frames = 0;
  int          frames_done = 0;
  int          word_no = 0;
  int          last_len = 0;
  logic [31:0] rx_words [0:255];
  bit          stalled = 1'b0;
  bit          last_pending = 1'b0;
  int          ready_mode = 0;

  always #5 clk = ~clk;

  run_test_readout #(.LANES(LANES), .CW(CW), .WORD_W(WW), .MAGIC(16'hA55A)) dut (
    .clk(clk), .rst(rst), .start(start), .run_count(run_count), .one_count(one_count),
    .total(total), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  run_test_readout #(.LANES(4), .CW(32), .WORD_W(32), .MAGIC(16'hA55A)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .run_count(s_run), .one_count(s_one),
    .total(s_total), .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
    .out_last(s_last), .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Reference frame: header, total LS word first, then per lane run then ones.
  function automatic void push_frame();
    word_t w;
    w.data = {16'hA55A, 8'(LANES), 8'(WPC)};
    w.last = 1'b0;
    exp_q.push_back(w);
    for (int k = 0; k < WPC; k++) begin
      w.data = WW'(total >> (WW * k));
      exp_q.push_back(w);
    end
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < WPC; k++) begin
        w.data = WW'(run_count[i] >> (WW * k));
        w.last = 1'b0;
        exp_q.push_back(w);
      end
      for (int k = 0; k < WPC; k++) begin
        w.data = WW'(one_count[i] >> (WW * k));
        w.last = (i == LANES - 1) && (k == WPC - 1);
        exp_q.push_back(w);
      end
    end
  endfunction

  // Ready pattern generator: always high, 1,0,0,1 repeating, or random.
  initial begin
    bit pat [4];
    int rcyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rcyc = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = pat[rcyc % 4];
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      rcyc++;
    end
  end

  // Monitor: every presented word must match the queue front; pop on transfer.
  always @(negedge clk) begin
    if (rst) begin
      stalled      = 1'b0;
      last_pending = 1'b0;
      word_no      = 0;
    end else begin
      chk("done_pulse", 64'(done), 64'(last_pending));
      last_pending = 1'b0;
      if (stalled) chk("valid_held", 64'(out_valid), 64'd1);
      stalled = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got=%h want=none", out_data);
        end else begin
          chk($sformatf("word%0d", word_no), 64'({out_last, out_data}),
              64'({exp_q[0].last, exp_q[0].data}));
          if (out_ready) begin
            if (word_no < 256) rx_words[word_no] = out_data;
            word_no++;
            if (exp_q[0].last) begin
              last_pending = 1'b1;
              last_len     = word_no;
              word_no      = 0;
              frames_done++;
            end
            void'(exp_q.pop_front());
          end else begin
            stalled = 1'b1;
          end
        end
      end
    end
  end

  task automatic set_plan_inputs();
    total = 64'h0000_0001_0000_0004;
    for (int i = 0; i < LANES; i++) begin
      run_count[i] = 64'(i);
      one_count[i] = 64'h1_0000_0000 + 64'(i);
    end
  endtask

  task automatic set_random_inputs();
    total = {$urandom(), $urandom()};
    for (int i = 0; i < LANES; i++) begin
      run_count[i] = {$urandom(), $urandom()};
      one_count[i] = {$urandom(), $urandom()};
    end
  endtask

  task automatic set_ones_inputs();
    total = '1;
    for (int i = 0; i < LANES; i++) begin
      run_count[i] = '1;
      one_count[i] = '1;
    end
  endtask

  task automatic issue_start();
    start = 1'b1;
    push_frame();
    exp_frames++;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(output int bcyc);
    bcyc = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy) return;
      bcyc++;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle_timeout got=busy want=idle");
  endtask

  task automatic wait_word(input int n);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      if (out_valid && word_no == n) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_word_timeout got=none want=word%0d", n);
  endtask

  initial begin
    int bcyc;
    int frames_before;
    logic [31:0] m [10];

    set_plan_inputs();
    for (int i = 0; i < 4; i++) begin
      s_run[i] = 32'h0;
      s_one[i] = 32'h0;
    end
    s_total = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single frame with known values, ready tied high
    set_plan_inputs();
    issue_start();
    wait_idle(bcyc);
    chk("busy_cycles", 64'(bcyc), 64'd132);
    chk("frame_len", 64'(last_len), 64'd131);
    chk("hdr", 64'(rx_words[0]), 64'hA55A_2002);
    chk("tot_lo", 64'(rx_words[1]), 64'd4);
    chk("tot_hi", 64'(rx_words[2]), 64'd1);
    chk("lane5_run_lo", 64'(rx_words[23]), 64'd5);
    chk("lane5_run_hi", 64'(rx_words[24]), 64'd0);
    chk("lane5_one_lo", 64'(rx_words[25]), 64'd5);
    chk("lane5_one_hi", 64'(rx_words[26]), 64'd1);

    // Backpressure 1,0,0,1 with the same contents
    ready_mode = 1;
    @(posedge clk);
    #1;
    issue_start();
    wait_idle(bcyc);
    chk("bp_frame_len", 64'(last_len), 64'd131);
    chk("bp_lane5_one_hi", 64'(rx_words[26]), 64'd1);

    // Snapshot isolation under random backpressure
    ready_mode = 2;
    @(posedge clk);
    #1;
    set_random_inputs();
    issue_start();
    set_ones_inputs();
    wait_idle(bcyc);
    chk("iso_frame_len", 64'(last_len), 64'd131);

    // Starts while busy, in FIN, and right after FIN
    ready_mode = 0;
    @(posedge clk);
    #1;
    set_random_inputs();
    issue_start();
    wait_word(10);
    set_random_inputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_word(130);
    set_random_inputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    begin : wait_done
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (done) disable wait_done;
      end
      checks++;
      errors++;
      $display("FAIL done_timeout got=0 want=1");
    end
    set_random_inputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    set_random_inputs();
    issue_start();
    wait_idle(bcyc);
    chk("restart_frame_len", 64'(last_len), 64'd131);

    // Reset in the middle of a frame
    @(posedge clk);
    #1;
    set_random_inputs();
    frames_before = frames_done;
    issue_start();
    wait_word(50);
    rst = 1'b1;
    exp_q.delete();
    exp_frames--;
    @(posedge clk);
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_frame", 64'(frames_done), 64'(frames_before));
    set_random_inputs();
    issue_start();
    wait_idle(bcyc);
    chk("post_rst_frame_len", 64'(last_len), 64'd131);
    chk("frames_total", 64'(frames_done), 64'(exp_frames));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    // Small variant: LANES=4, CW=32
    @(posedge clk);
    #1;
    s_total = $urandom();
    for (int i = 0; i < 4; i++) begin
      s_run[i] = $urandom();
      s_one[i] = $urandom();
    end
    m[0] = 32'hA55A_0401;
    m[1] = s_total;
    for (int i = 0; i < 4; i++) begin
      m[2 + 2 * i] = s_run[i];
      m[3 + 2 * i] = s_one[i];
    end
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_run[i] = '1;
      s_one[i] = '1;
    end
    s_total = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) chk("small_busy", 64'(s_busy), 64'd1);
      chk($sformatf("small_word%0d", i), 64'({s_valid, s_last, s_data}),
          64'({1'b1, (i == 9) ? 1'b1 : 1'b0, m[i]}));
    end
    @(negedge clk);
    chk("small_done", 64'(s_done), 64'd1);
    chk("small_valid_end", 64'(s_valid), 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_test_readout.md
Name: run_test_readout

Overview:
- Reader side of the per-lane runs/ones counter bank.
- On a start request, snapshots all lane counters and the sample total in one cycle.
- Serializes the snapshot as a framed 32-bit word stream over a valid/ready interface toward the host link.
- The counter bank may be cleared or keep running after the snapshot without corrupting the frame in flight.

Parameters:
- LANES, 32: number of bit lanes, i.e. counter pairs.
- CW, 64: counter width in bits. Must be a multiple of WORD_W.
- WORD_W, 32: output word width.
- MAGIC, 16'hA55A: frame header tag.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  snapshot-and-send request. Sampled only in IDLE.
- run_count  in  LANES x CW  per-lane transition counters, unpacked array [LANES-1:0].
- one_count  in  LANES x CW  per-lane ones counters, unpacked array [LANES-1:0].
- total  in  CW  samples processed.
- out_data  out  WORD_W  stream word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  marks the final word of the frame.
- busy  out  1  high from the snapshot cycle until the last word is accepted.
- done  out  1  one-cycle pulse after the last word handshake.

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE. out_valid, out_last, busy, done and out_data all become 0. The snapshot is not cleared.
- Reset mid-frame: the frame is abandoned on the next edge and no done pulse is issued. Downstream must discard the partial frame when it sees no out_last.
- States:
  - IDLE: on start=1, capture all inputs into the snapshot and go to HDR. busy=1 from the next cycle.
  - HDR: emit {MAGIC, LANES[7:0], (CW/WORD_W)[7:0]}.
  - TOT: emit total, least-significant word first, CW/WORD_W words.
  - LANE: for lane i = 0 .. LANES-1, emit run_count[i] words (LS first), then one_count[i] words (LS first).
  - FIN: done=1 for one cycle, then return to IDLE.
- Frame length: 1 + (CW/WORD_W)*(1 + 2*LANES) words. Defaults give 131.
- Latency: out_valid rises the cycle after start is sampled.
- Handshake rules:
  - A word transfers on a cycle with out_valid and out_ready both high.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops without a transfer.
  - At most one word per cycle. Back-to-back transfers are supported, so full throughput is 1 word/cycle with out_ready tied high.
- out_last is high only on the final one_count[LANES-1] most-significant word.
- Indexing: word index counter width is clog2 of the frame length. Lane index and sub-word index wrap to 0 on leaving LANE.
- Simultaneous events:
  - start while busy is ignored; it is not queued.
  - start in the FIN cycle is ignored.
  - start in the IDLE cycle immediately after FIN is accepted.
- The snapshot is immune to input changes after the capture cycle.
- out_data is registered; no combinational path from inputs to outputs.

Decomposition:
- Package run_test_pkg holds:
  - Default values of LANES, CW, WORD_W and MAGIC.
  - FSM state enum (IDLE, HDR, TOT, LANE, FIN).
  - A function computing the frame length.
  - The header-word packing function.
- One sub-module: word_mux_reg. It selects the CW-bit snapshot word by sub-index and holds the registered out_data/out_valid under backpressure.

Test Plan:
- Single frame, ready tied high, LANES=32:
  - Stimulus: total=64'h0000_0001_0000_0004, run_count[i]=i, one_count[i]=64'h1_0000_0000+i, start pulse.
  - Response: 131 consecutive words.
  - Word0 = 32'hA55A_2002; words1-2 = 4, 1.
  - Lane 5 words (indices 23-26) = 5, 0, 5, 1.
  - out_last only on word 130; done pulses one cycle later; busy is high for 132 cycles.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeatedly.
  - Response: out_data is unchanged across stalled cycles, no words are lost or duplicated, and the frame contents equal the single-frame case.
- Snapshot isolation:
  - Stimulus: after start, force all inputs to 64'hFFFF_FFFF_FFFF_FFFF.
  - Response: the streamed words still carry the pre-start values.
- Start while busy:
  - Stimulus: pulse start at words 10 and 130.
  - Response: only one frame is emitted. A start on the cycle after done launches a second full frame.
- Reset mid-frame:
  - Stimulus: assert rst at word 50.
  - Response: next cycle out_valid=0 and busy=0; no done or out_last is seen. A following start yields a complete 131-word frame.
- Parameter variant LANES=4, CW=32:
  - Response: header = 32'hA55A_0401; frame is 10 words.
